// File: rtl/stream_min_select.sv
// stream_min_select: serial argmin over a valid/ready stream of (data, id) candidates.
// Define STREAM_MIN_MAX_MODE_EN to select the maximum instead of the minimum.
module stream_min_select #(
   parameter int ADDW = 14,
   parameter int IDW  = 3,
   parameter int NUM  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ADDW-1:0] in_data,
   input  logic [IDW-1:0]  in_id,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ADDW-1:0] out_data,
   output logic [IDW-1:0]  out_id,
   output logic [7:0]      out_cnt
);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t          state, state_nxt;
   logic [ADDW-1:0] best_data, best_data_nxt;
   logic [IDW-1:0]  best_id, best_id_nxt;
   logic [7:0]      count, count_nxt, count_inc;
   logic            accept, better, close;

   assign in_ready  = (state == COLLECT);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign count_inc = count + 8'd1;

   // Strict compare so that on a tie the earlier candidate stays the winner.
`ifdef STREAM_MIN_MAX_MODE_EN
   assign better = (in_data > best_data);
`else
   assign better = (in_data < best_data);
`endif

   always_comb begin
      state_nxt     = state;
      best_data_nxt = best_data;
      best_id_nxt   = best_id;
      count_nxt     = count;
      close         = 1'b0;
      case (state)
         COLLECT: begin
            if (accept) begin
               count_nxt = count_inc;
               if ((count == 8'd0) || better) begin
                  best_data_nxt = in_data;
                  best_id_nxt   = in_id;
               end
               if (in_last || (count_inc == 8'(NUM))) begin
                  close     = 1'b1;
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt = COLLECT;
               count_nxt = 8'd0;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // The result registers capture the winner including the closing beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         best_data <= '0;
         best_id   <= '0;
         count     <= 8'd0;
         out_data  <= '0;
         out_id    <= '0;
         out_cnt   <= 8'd0;
      end else begin
         state     <= state_nxt;
         best_data <= best_data_nxt;
         best_id   <= best_id_nxt;
         count     <= count_nxt;
         if (close) begin
            out_data <= best_data_nxt;
            out_id   <= best_id_nxt;
            out_cnt  <= count_inc;
         end
      end
   end

endmodule
